// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: funct3 outcome decode, misprediction flush/redirect,
// and a 2-bit saturating-counter BHT that serves predictions to fetch.
module branch_resolve_unit #(
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchPc,
  output logic        predTaken,
  input  logic        exValid,
  input  logic        exStall,
  input  logic [2:0]  exFunct3,
  input  logic [31:0] exPc,
  input  logic [31:0] exTarget,
  input  logic        exPredTaken,
  input  logic        brEq,
  input  logic        brLt,
  output logic        brUn,
  output logic        flush,
  output logic [31:0] redirectPc,
  output logic        illegalBr,
  output logic [31:0] branchCnt,
  output logic [31:0] mispredCnt
);

  logic [1:0]       bht [BHT_DEPTH];
  logic             taken_p0;
  logic             legal_p0;
  logic             accept_p0;
  logic             mispred_p0;
  logic [IDX_W-1:0] rdIdx;
  logic [IDX_W-1:0] wrIdx;
  logic             unusedPcBits;

  function automatic logic [1:0] satStep(input logic [1:0] cnt, input logic up);
    if (up)
      return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  assign rdIdx        = fetchPc[IDX_W+1:2];
  assign wrIdx        = exPc[IDX_W+1:2];
  assign unusedPcBits = ^{fetchPc[31:IDX_W+2], fetchPc[1:0]};

  // Reads see the pre-update counter when fetch and EX hit the same entry.
  assign predTaken = bht[rdIdx][1];
  assign brUn      = (exFunct3[2:1] == 2'b11);

  always_comb begin
    taken_p0 = 1'b0;
    legal_p0 = 1'b1;
    case (exFunct3)
      3'b000:  taken_p0 = brEq;
      3'b001:  taken_p0 = !brEq;
      3'b100:  taken_p0 = brLt;
      3'b101:  taken_p0 = !brLt;
      3'b110:  taken_p0 = brLt;
      3'b111:  taken_p0 = !brLt;
      default: legal_p0 = 1'b0;
    endcase
  end

  // A live flush marks the EX instruction as wrong-path, so it must not resolve.
  assign accept_p0  = exValid && !exStall && !flush;
  assign mispred_p0 = (taken_p0 != exPredTaken);

  // EX -> fetch response registers (p1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush      <= 1'b0;
      illegalBr  <= 1'b0;
      redirectPc <= 32'd0;
      branchCnt  <= 32'd0;
      mispredCnt <= 32'd0;
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else begin
      flush     <= accept_p0 && legal_p0 && mispred_p0;
      illegalBr <= accept_p0 && !legal_p0;
      if (accept_p0 && legal_p0) begin
        branchCnt  <= branchCnt + 32'd1;
        mispredCnt <= mispredCnt + {31'd0, mispred_p0};
        bht[wrIdx] <= satStep(bht[wrIdx], taken_p0);
        if (mispred_p0)
          redirectPc <= taken_p0 ? exTarget : exPc + 32'd4;
      end
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EX-stage consumer of the Branch comparator outputs (brEq/brLt). It drives brUn back to the comparator and decodes funct3 into a taken/not-taken outcome. It checks that outcome against the prediction carried down the pipeline and issues a registered flush/redirect to fetch. It also owns a 2-bit saturating-counter branch history table (BHT) that supplies predictions to IF and counts branches and mispredictions.

Parameters:
BHT_DEPTH, 16, number of BHT entries; must be a power of 2.
IDX_W, 4, BHT index width; must equal log2(BHT_DEPTH).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
fetchPc  input  32  IF-stage PC for prediction lookup
predTaken  output  1  BHT prediction for fetchPc (counter MSB), combinational read
exValid  input  1  EX stage holds a conditional branch
exStall  input  1  EX stage stalled this cycle
exFunct3  input  3  branch funct3 of EX instruction
exPc  input  32  PC of EX branch
exTarget  input  32  computed branch target (PC+imm)
exPredTaken  input  1  prediction made at fetch for the EX branch
brEq  input  1  from comparator: dataA == dataB
brLt  input  1  from comparator: dataA < dataB (signed/unsigned per brUn)
brUn  output  1  unsigned-compare select to comparator
flush  output  1  one-cycle pulse: squash IF/ID, redirect fetch
redirectPc  output  32  fetch target, valid while flush=1
illegalBr  output  1  one-cycle pulse: reserved funct3 seen
branchCnt  output  32  resolved-branch counter
mispredCnt  output  32  misprediction counter

Behaviour:
- brUn is combinational: 1 iff exFunct3 is 110 (BLTU) or 111 (BGEU), otherwise 0. It is independent of exValid.
- taken decode:
  - 000 BEQ = brEq; 001 BNE = !brEq
  - 100 BLT = brLt; 101 BGE = !brLt
  - 110 BLTU = brLt; 111 BGEU = !brLt
  - 010/011 are reserved: not taken.
- A branch is accepted on a rising edge when exValid=1, exStall=0 and flush=0.
  - flush=1 means the EX instruction is wrong-path; it is ignored with no update and no count.
- On accept with legal funct3:
  - mispredict = (taken != exPredTaken).
  - Next cycle: flush=mispredict, for exactly one cycle.
  - redirectPc = exTarget if taken, else exPc+4 (32-bit wrap-around, e.g. 0xFFFFFFFC+4 = 0).
  - branchCnt += 1; mispredCnt += mispredict. Both counters wrap modulo 2^32.
  - BHT[exPc[IDX_W+1:2]] increments if taken, decrements if not taken, saturating at 00 and 11.
- On accept with reserved funct3:
  - Next cycle: illegalBr=1 for one cycle.
  - No flush, no BHT update, no counter change.
- Latency: accept edge to flush/redirectPc/illegalBr visible is 1 cycle (registered). The pulses deassert the following cycle unless a new accept occurs.
- redirectPc holds its last value when flush=0.
- BHT read/write collision: if fetchPc and exPc map to the same index in the same cycle, predTaken reflects the pre-update value. The new value is visible the cycle after the edge.
- Reset (asynchronous, active-high; also mid-operation):
  - flush=0, illegalBr=0, redirectPc=0, branchCnt=0, mispredCnt=0.
  - All BHT entries = 01 (weakly not-taken), so predTaken=0 for all PCs.
  - A pending flush is cancelled immediately.
- exStall=1 with exValid=1 holds the branch: no update. The branch resolves on the first unstalled edge.
- Back-to-back accepts on consecutive cycles are legal (flush=0 between them). Each produces its own 1-cycle response.

Test Plan:
1. Reset: rst=1 mid-run with flush pending -> flush=0 immediately, counters=0, predTaken=0 for fetchPc=0x00,0x04,0x3C.
2. BEQ mispredict: exFunct3=000, brEq=1, exPredTaken=0, exPc=0x100, exTarget=0x140 -> next cycle flush=1, redirectPc=0x140, branchCnt=1, mispredCnt=1. BHT[0] goes 01->10, so fetchPc=0x100 gives predTaken=1.
3. BGEU correct prediction: exFunct3=111 -> brUn=1; brLt=0, exPredTaken=1 -> flush=0, branchCnt+=1, mispredCnt unchanged. BLT (100) -> brUn=0.
4. Not-taken redirect with wrap: BNE, brEq=1, exPredTaken=1, exPc=0xFFFFFFFC -> flush=1, redirectPc=0x00000000.
5. Saturation and collision: four consecutive taken branches at exPc=0x20 -> counter saturates at 11. A same-cycle fetchPc=0x20 lookup returns the old value.
6. Filtering: exFunct3=010 -> illegalBr pulse, no flush, counts unchanged. exValid=1 during flush=1 -> ignored. exStall=1 for 3 cycles -> a single resolution after the stall drops.
